test_sequencer: RTL and testbench

- Hardware-side counterpart of the simulation suite runner for the board-level self-test.
- Launches NUM_UNITS self-test units in strict order and collects each unit's done/error report.
- Enforces a per-unit cycle timeout; a timeout aborts the whole run.
- Publishes an aggregated pass/fail result and a saturating total error count to the AXI-lite slave register bank.

---
 rtl/test_seq_pkg.sv | 32 +++
 rtl/cycle_watchdog.sv | 43 ++++
 rtl/test_sequencer.sv | 138 +++++++++++++
 tb/tb_test_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/test_seq_pkg.sv
//------------------------------------------------------------------------------
// test_seq_pkg - state encoding and arithmetic helpers for test_sequencer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package test_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_LAUNCH = 3'd1;
  localparam state_t S_WAIT   = 3'd2;
  localparam state_t S_ACCUM  = 3'd3;
  localparam state_t S_REPORT = 3'd4;

  function automatic int unit_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Saturates at 2^w-1; callers pass operands zero-extended and truncate the result to w bits.
  function automatic logic [32:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim : sum;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cycle_watchdog.sv
//------------------------------------------------------------------------------
// cycle_watchdog - cycle counter that flags the LIMIT-th counted cycle
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cycle_watchdog #(
  parameter int LIMIT = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = run && (count_q == CW'(LIMIT - 1));

endmodule

`default_nettype wire

// File: rtl/test_sequencer.sv
//------------------------------------------------------------------------------
// test_sequencer - runs self-test units in order, aggregates errors, enforces timeout
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module test_sequencer
  import test_seq_pkg::*;
#(
  parameter int  NUM_UNITS      = 9,
  parameter int  TIMEOUT_CYCLES = 1000,
  parameter int  ERR_W          = 16,
  localparam int UW             = unit_idx_w(NUM_UNITS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  output logic [NUM_UNITS-1:0] unit_start_o,
  input  logic [NUM_UNITS-1:0] unit_done_i,
  input  logic [ERR_W-1:0]     unit_err_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic                 timed_out_o,
  output logic [ERR_W-1:0]     total_errors_o,
  output logic [UW-1:0]        active_unit_o
);

  localparam logic [UW-1:0] LAST_UNIT = UW'(NUM_UNITS - 1);

  state_t           state_q, state_d;
  logic [UW-1:0]    active_q, active_d;
  logic [ERR_W-1:0] total_q, total_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             pass_q, pass_d;
  logic             to_q, to_d;
  logic             wd_clear;
  logic             wd_run;
  logic             wd_expired;
  logic             unit_done_w;

  assign unit_done_w = unit_done_i[active_q];

  // The timeout window opens with the launch cycle, so TIMEOUT_CYCLES counts from the launch pulse.
  assign wd_clear = (state_d == S_LAUNCH);
  assign wd_run   = (state_q == S_LAUNCH) || (state_q == S_WAIT);

  cycle_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .run     (wd_run),
    .expired (wd_expired)
  );

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    total_d  = total_q;
    err_d    = err_q;
    pass_d   = pass_q;
    to_d     = to_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          total_d  = '0;
          to_d     = 1'b0;
          pass_d   = 1'b0;
          active_d = '0;
          state_d  = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (unit_done_w) begin
          err_d   = unit_err_i;
          state_d = S_ACCUM;
        end else if (wd_expired) begin
          to_d    = 1'b1;
          total_d = ERR_W'(sat_add(32'(total_q), 32'd1, ERR_W));
          state_d = S_REPORT;
        end
      end
      S_ACCUM: begin
        total_d = ERR_W'(sat_add(32'(total_q), 32'(err_q), ERR_W));
        if (active_q == LAST_UNIT) begin
          state_d = S_REPORT;
        end else begin
          active_d = active_q + 1'b1;
          state_d  = S_LAUNCH;
        end
      end
      S_REPORT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Verdict is registered on entry so it is already valid alongside done_o.
    if (state_d == S_REPORT) begin
      pass_d = (total_d == '0) && !to_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      active_q <= '0;
      total_q  <= '0;
      err_q    <= '0;
      pass_q   <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      total_q  <= total_d;
      err_q    <= err_d;
      pass_q   <= pass_d;
      to_q     <= to_d;
    end
  end

  assign unit_start_o   = (state_q == S_LAUNCH) ? (NUM_UNITS'(1) << active_q) : '0;
  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = (state_q == S_REPORT);
  assign pass_o         = pass_q;
  assign timed_out_o    = to_q;
  assign total_errors_o = total_q;
  assign active_unit_o  = active_q;

endmodule

`default_nettype wire

// File: tb/tb_test_sequencer.sv
//------------------------------------------------------------------------------
// tb_test_sequencer - table-driven checks of test_sequencer with a unit responder model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_test_sequencer;

  localparam int N  = 9;
  localparam int EW = 16;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          start_i = 1'b0;
  logic [N-1:0]  unit_start_o;
  logic [N-1:0]  unit_done_i = '0;
  logic [EW-1:0] unit_err_i  = '0;
  logic          busy_o, done_o, pass_o, timed_out_o;
  logic [EW-1:0] total_errors_o;
  logic [3:0]    active_unit_o;

  logic       s_start = 1'b0;
  logic [1:0] s_ustart;
  logic [1:0] s_done  = 2'b00;
  logic [3:0] s_err   = 4'd0;
  logic       s_busy, s_donep, s_pass, s_to;
  logic [3:0] s_total;
  logic       s_active;

  always #5 clk = ~clk;

  test_sequencer #(.NUM_UNITS(N), .TIMEOUT_CYCLES(1000), .ERR_W(EW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .unit_start_o(unit_start_o),
    .unit_done_i(unit_done_i), .unit_err_i(unit_err_i), .busy_o(busy_o), .done_o(done_o),
    .pass_o(pass_o), .timed_out_o(timed_out_o), .total_errors_o(total_errors_o),
    .active_unit_o(active_unit_o)
  );

  test_sequencer #(.NUM_UNITS(2), .TIMEOUT_CYCLES(1000), .ERR_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start_i(s_start), .unit_start_o(s_ustart),
    .unit_done_i(s_done), .unit_err_i(s_err), .busy_o(s_busy), .done_o(s_donep),
    .pass_o(s_pass), .timed_out_o(s_to), .total_errors_o(s_total), .active_unit_o(s_active)
  );

  int checks = 0;
  int errors = 0;

  // Responder configuration (written by the main sequence) and observations.
  int dly[N];
  int errs[N];
  int due[N];
  int launch_cyc[N];
  int cyc = 0, launches = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;
  int stray_trig = -1, stray_off = 0, stray_bit = 0, stray_at = -1;

  initial begin
    logic [N-1:0]  nd;
    logic [EW-1:0] ne;
    for (int k = 0; k < N; k++) begin
      due[k] = -1;
      launch_cyc[k] = 0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      nd = '0;
      ne = '0;
      if (!rst_n) begin
        for (int k = 0; k < N; k++) due[k] = -1;
        stray_at = -1;
      end else begin
        for (int k = 0; k < N; k++) begin
          if (due[k] == cyc) begin
            nd[k] = 1'b1;
            ne = EW'(errs[k]);
            due[k] = -1;
          end
        end
        if (stray_at == cyc) begin
          nd[stray_bit] = 1'b1;
          stray_at = -1;
        end
        for (int k = 0; k < N; k++) begin
          if (unit_start_o[k]) begin
            launches++;
            launch_cyc[k] = cyc;
            if (dly[k] > 0) due[k] = cyc + dly[k];
            if (k == stray_trig) stray_at = cyc + stray_off;
          end
        end
        if (start_i && !busy_o) start_cyc = cyc;
        if (done_o) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
      unit_done_i = nd;
      unit_err_i  = ne;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
  endtask

  task automatic wait_done(input int base, input int bound, input string name);
    int i;
    i = 0;
    while (done_cnt == base && i < bound) begin
      @(negedge clk);
      i++;
    end
    checks++;
    if (done_cnt == base) begin
      errors++;
      $display("FAIL %s: done_o not seen within %0d cycles, expected a pulse", name, bound);
    end
  endtask

  task automatic set_defaults();
    for (int k = 0; k < N; k++) begin
      dly[k]  = 5;
      errs[k] = 0;
    end
  endtask

  typedef struct {
    int   ua; int ea;          // unit/err pair A (-1 none)
    int   ub; int eb;          // unit/err pair B (-1 none)
    int   slow_u; int slow_d;  // unit with non-default delay, 0 = never completes
    logic exp_pass;
    logic exp_to;
    int   exp_total;
    int   exp_active;
    int   exp_launch;
  } vec_t;

  vec_t tv[6];

  initial begin
    int lbase, dbase, bad, i;

    tv[0] = '{-1, 0, -1, 0, -1,   0, 1'b1, 1'b0,     0, 8, 9};
    tv[1] = '{ 2, 3,  5, 4, -1,   0, 1'b0, 1'b0,     7, 8, 9};
    tv[2] = '{-1, 0, -1, 0,  3,   0, 1'b0, 1'b1,     1, 3, 4};
    tv[3] = '{-1, 0, -1, 0,  1, 999, 1'b1, 1'b0,     0, 8, 9};
    tv[4] = '{ 0, 65535, 8, 5, -1, 0, 1'b0, 1'b0, 65535, 8, 9};
    tv[5] = '{ 4, 1, -1, 0,  8,   0, 1'b0, 1'b1,     2, 8, 9};

    set_defaults();

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_start", unit_start_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_pass", pass_o, 0);
    chk("rst_to", timed_out_o, 0);
    chk("rst_total", total_errors_o, 0);
    chk("rst_active", active_unit_o, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      set_defaults();
      if (tv[v].ua >= 0) errs[tv[v].ua] = tv[v].ea;
      if (tv[v].ub >= 0) errs[tv[v].ub] = tv[v].eb;
      if (tv[v].slow_u >= 0) dly[tv[v].slow_u] = tv[v].slow_d;
      lbase = launches;
      dbase = done_cnt;
      pulse_start();
      wait_done(dbase, 3000, $sformatf("v%0d_wait", v));
      repeat (5) @(negedge clk);
      chk($sformatf("v%0d_pass", v), pass_o, tv[v].exp_pass);
      chk($sformatf("v%0d_timed_out", v), timed_out_o, tv[v].exp_to);
      chk($sformatf("v%0d_total", v), total_errors_o, tv[v].exp_total);
      chk($sformatf("v%0d_active", v), active_unit_o, tv[v].exp_active);
      chk($sformatf("v%0d_launches", v), launches - lbase, tv[v].exp_launch);
      chk($sformatf("v%0d_done_pulses", v), done_cnt - dbase, 1);
      chk($sformatf("v%0d_start_latency", v), launch_cyc[0] - start_cyc, 1);
      if (tv[v].exp_to)
        chk($sformatf("v%0d_timeout_latency", v), done_cyc - launch_cyc[tv[v].exp_active], 1000);
      if (tv[v].slow_u < 0) begin
        bad = 0;
        for (int k = 1; k < N; k++) if (launch_cyc[k] - launch_cyc[k-1] != 7) bad++;
        chk($sformatf("v%0d_spacing_bad", v), bad, 0);
      end
    end

    // Stray done for a non-active unit and a mid-run start request
    set_defaults();
    dly[1] = 20;
    stray_trig = 1; stray_off = 3; stray_bit = 6;
    lbase = launches;
    dbase = done_cnt;
    pulse_start();
    repeat (10) @(negedge clk);
    chk("stray_busy", busy_o, 1);
    pulse_start();
    wait_done(dbase, 3000, "stray_wait");
    repeat (20) @(negedge clk);
    stray_trig = -1;
    chk("stray_done_pulses", done_cnt - dbase, 1);
    chk("stray_launches", launches - lbase, 9);
    chk("stray_unit1_span", launch_cyc[2] - launch_cyc[1], 22);
    chk("stray_pass", pass_o, 1);

    // Reset during unit 4's WAIT, then a fresh run
    set_defaults();
    errs[2] = 3;
    lbase = launches;
    pulse_start();
    i = 0;
    while (launches - lbase < 5 && i < 200) begin
      @(negedge clk);
      i++;
    end
    chk("mid_reached_unit4", launches - lbase, 5);
    @(negedge clk);
    @(negedge clk);
    chk("mid_pre_active", active_unit_o, 4);
    chk("mid_pre_total", total_errors_o, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_active", active_unit_o, 0);
    chk("mid_rst_total", total_errors_o, 0);
    chk("mid_rst_start", unit_start_o, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    lbase = launches;
    repeat (5) @(negedge clk);
    chk("mid_no_launch_on_release", launches - lbase, 0);
    chk("mid_idle_after_release", busy_o, 0);
    dbase = done_cnt;
    pulse_start();
    wait_done(dbase, 3000, "mid_rerun_wait");
    repeat (3) @(negedge clk);
    chk("mid_rerun_launches", launches - lbase, 9);
    chk("mid_rerun_start_latency", launch_cyc[0] - start_cyc, 1);
    chk("mid_rerun_total", total_errors_o, 3);
    chk("mid_rerun_pass", pass_o, 0);

    // Saturation on the 4-bit instance: 12 + 9 clamps to 15
    @(posedge clk); #1 s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    for (int u = 0; u < 2; u++) begin
      i = 0;
      while (!s_ustart[u] && i < 100) begin
        @(negedge clk);
        i++;
      end
      chk($sformatf("sat_launch%0d", u), s_ustart[u], 1);
      @(posedge clk); #1 s_done = 2'(1 << u); s_err = (u == 0) ? 4'd12 : 4'd9;
      @(posedge clk); #1 s_done = 2'b00;      s_err = 4'd0;
    end
    i = 0;
    while (!s_donep && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk("sat_done", s_donep, 1);
    chk("sat_total", s_total, 15);
    chk("sat_pass", s_pass, 0);
    chk("sat_timed_out", s_to, 0);
    chk("sat_active", s_active, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
